dma_done_tracker: RTL and testbench
===================================

Name: dma_done_tracker

Overview:
- Tracks host DMA read and write requests from start to finish and drives the level done signals that the interrupt manager edge-detects.
- Each direction is loaded with a request length in DW at start and is decremented as completion or write TLPs are reported by the TX/RX engines.
- Done is asserted when the remaining count reaches 0, on an overrun, or on a timeout.
- Provides per-direction status and counters for the register file.

Parameters:
- LEN_W, 16, width of request length in DW (max 65535 DW per request).
- TLP_LEN_W, 10, width of per-TLP payload length in DW.
- TIMEOUT_CYCLES, 32'd1_000_000, idle cycles in BUSY with no progress before timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  global enable; low behaves as reset
- rd_req_start_i  in  1  one-cycle pulse: new read (host-to-card) request
- rd_req_len_i  in  LEN_W  read request length in DW, sampled with start
- rd_cpl_valid_i  in  1  one-cycle pulse per completion TLP received
- rd_cpl_len_i  in  TLP_LEN_W  payload DW of that completion
- wr_req_start_i  in  1  new write (card-to-host) request pulse
- wr_req_len_i  in  LEN_W  write request length in DW
- wr_tlp_sent_i  in  1  pulse per memory-write TLP accepted by the core
- wr_tlp_len_i  in  TLP_LEN_W  payload DW of that TLP
- rd_req_done_o  out  1  level; read request finished
- wr_req_done_o  out  1  level; write request finished
- rd_busy_o, wr_busy_o  out  1  channel in BUSY
- rd_status_o, wr_status_o  out  2  00 ok, 01 overrun, 10 timeout, 11 start-while-busy (sticky)
- rd_done_cnt_o, wr_done_cnt_o  out  32  requests finished since reset

Behaviour:
- Reset (rst_n=0 or en=0, synchronous): all outputs 0; channel state IDLE; remaining=0; timer=0.
- The two channels are independent and identical.
- Per-channel FSM states: IDLE, BUSY, DONE.
- IDLE/DONE + start, len!=0:
  - Next cycle: state=BUSY, remaining=len, done=0, busy=1, status=00, timer=0.
- IDLE/DONE + start, len==0:
  - Next cycle: state=DONE, done=1, status=00, done_cnt+1.
  - Done does not stay low for a cycle, so no new rising edge is produced; software relies on done_cnt.
- A valid/sent pulse outside BUSY is ignored entirely.
- BUSY + valid, tlp_len<remaining:
  - remaining -= tlp_len; timer=0.
- BUSY + valid, tlp_len==remaining:
  - Next cycle: state=DONE, done=1, busy=0, done_cnt+1, status=00.
- BUSY + valid, tlp_len>remaining:
  - Next cycle: state=DONE, done=1, status=01, done_cnt+1, remaining=0.
- BUSY with no valid: timer+1.
  - When timer==TIMEOUT_CYCLES-1, next cycle: state=DONE, done=1, status=10, done_cnt+1.
- BUSY + start (with or without valid):
  - The start is dropped and status becomes 11 (sticky until the next accepted start).
  - A valid pulse in the same cycle is still processed. If that completion finishes the request, status stays 11.
- Done stays high in DONE until the next accepted start. It deasserts one cycle after that start, which gives the interrupt manager a fresh 0->1 edge at completion.
- Latency: last TLP pulse at cycle N -> done high at N+1.
- done_cnt wraps 0xFFFFFFFF -> 0.
- Timer width is 32 bits; it saturates and never wraps while in BUSY.
- Length arithmetic:
  - tlp_len is zero-extended to LEN_W.
  - A tlp_len of 0 is treated as 1024 DW (PCIe encoding). TLP_LEN_W=10 is required for this.
- Reset or en low mid-request: the channel returns to IDLE with done=0. Completions already in flight are ignored.

Decomposition:
- Shared package dma_trk_pkg holds:
  - state encodings: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - status codes: ST_OK, ST_OVR, ST_TMO, ST_BSY;
  - default widths.
- One sub-module, dma_chan_tracker: one FSM, remaining counter, timer, status and done_cnt.
- The top instantiates it twice (rd, wr) and only renames ports.

Test Plan:
- Read start len=64, four cpls of 16 DW each one cycle apart -> rd_req_done_o rises the cycle after the 4th cpl, status 00, rd_done_cnt_o=1, wr side untouched.
- Write start len=100, TLPs of 32, 32, 32, 8 -> after 3 TLPs remaining=4 and done=0; after the 8-DW TLP done=1 with status 01 (overrun).
- TIMEOUT_CYCLES=16, read start len=8, no cpl -> done=1 and status 10 exactly 16 cycles after BUSY is entered; a cpl arriving afterwards has no effect.
- Read start len=32 while BUSY from an earlier len=32 request, together with a 32-DW cpl in the same cycle -> second start dropped, done=1, status 11, done_cnt+1 only.
- cpl tlp_len=0 with request len=1024 -> done next cycle, status 00. Then start len=0 -> done stays 1 and done_cnt increments.
- Read start len=64, one 16-DW cpl, then en=0 for 1 cycle -> busy=0, done=0, counters 0; subsequent cpl pulses ignored.

Source files
------------

// File: rtl/dma_trk_pkg.sv
// dma_trk_pkg
//   Shared definitions for the DMA done tracker: channel FSM state
//   encodings, status codes reported to the register file, and default
//   widths/timeout used by the tracker modules.
// Ports: none (package).
package dma_trk_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } chan_state_t;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_OVR = 2'b01,
        ST_TMO = 2'b10,
        ST_BSY = 2'b11
    } status_t;

    localparam int          DEF_LEN_W     = 16;
    localparam int          DEF_TLP_LEN_W = 10;
    localparam logic [31:0] DEF_TIMEOUT   = 32'd1_000_000;

endpackage

// File: rtl/dma_chan_tracker.sv
// dma_chan_tracker
//   Tracks one DMA direction: loads a request length on start, subtracts
//   the payload of each reported TLP, and finishes on exact completion,
//   overrun or idle timeout. Keeps sticky status and a finished-request
//   counter.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   en           global enable, low acts as reset
//   start        request start pulse, req_len sampled with it
//   tlp_valid    one pulse per TLP, tlp_len payload in DW (0 = 1024)
//   done, busy   registered level outputs
//   status       00 ok, 01 overrun, 10 timeout, 11 start-while-busy
//   done_cnt     requests finished since reset (wraps)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no request since reset/disable
// S_BUSY | request in flight, counting down remaining DW
// S_DONE | request finished, done held high until next accepted start
module dma_chan_tracker
    import dma_trk_pkg::*;
#(
    parameter int          LEN_W          = DEF_LEN_W,
    parameter int          TLP_LEN_W      = DEF_TLP_LEN_W,
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic [LEN_W-1:0]     req_len,
    input  logic                 tlp_valid,
    input  logic [TLP_LEN_W-1:0] tlp_len,
    output logic                 done,
    output logic                 busy,
    output logic [1:0]           status,
    output logic [31:0]          done_cnt
);

    // The idle timer runs as a down-counter: loading TIMEOUT_CYCLES-1 and
    // expiring at zero gives the same timeout cycle as an up-count from 0.
    localparam logic [31:0] TMO_LOAD = TIMEOUT_CYCLES - 32'd1;

    chan_state_t      state;
    status_t          status_q;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      tmr;
    logic [LEN_W:0]   tlp_ext;
    logic [LEN_W:0]   rem_ext;
    logic             keep_bsy;

    // A zero payload length is the PCIe encoding for 1024 DW.
    assign tlp_ext  = (tlp_len == '0) ? (LEN_W+1)'(1024) : (LEN_W+1)'(tlp_len);
    assign rem_ext  = {1'b0, remaining};
    // A start seen while busy must survive whatever ends this request.
    assign keep_bsy = start || (status_q == ST_BSY);
    assign status   = status_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            state     <= S_IDLE;
            status_q  <= ST_OK;
            remaining <= '0;
            tmr       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            done_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        status_q <= ST_OK;
                        if (req_len == '0) begin
                            state     <= S_DONE;
                            remaining <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            done_cnt  <= done_cnt + 32'd1;
                        end else begin
                            state     <= S_BUSY;
                            remaining <= req_len;
                            tmr       <= TMO_LOAD;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    if (start)
                        status_q <= ST_BSY;
                    if (tlp_valid) begin
                        tmr <= TMO_LOAD;
                        if (tlp_ext < rem_ext) begin
                            remaining <= remaining - tlp_ext[LEN_W-1:0];
                        end else begin
                            state     <= S_DONE;
                            remaining <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            done_cnt  <= done_cnt + 32'd1;
                            if (!keep_bsy && (tlp_ext != rem_ext))
                                status_q <= ST_OVR;
                        end
                    end else if (tmr == '0) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        done_cnt <= done_cnt + 32'd1;
                        if (!keep_bsy)
                            status_q <= ST_TMO;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dma_done_tracker.sv
// dma_done_tracker
//   Level done tracking for host DMA reads and writes. Two independent
//   channel trackers; this level only maps the rd/wr port names.
// Ports:
//   clk, rst_n, en                       clock, sync active-low reset, enable
//   rd_req_start_i / rd_req_len_i        read request start and length (DW)
//   rd_cpl_valid_i / rd_cpl_len_i        completion TLP pulse and payload
//   wr_req_start_i / wr_req_len_i        write request start and length (DW)
//   wr_tlp_sent_i / wr_tlp_len_i         memory-write TLP pulse and payload
//   rd_/wr_req_done_o, rd_/wr_busy_o     level done / busy
//   rd_/wr_status_o, rd_/wr_done_cnt_o   status and finished-request count
module dma_done_tracker
    import dma_trk_pkg::*;
#(
    parameter int          LEN_W          = DEF_LEN_W,
    parameter int          TLP_LEN_W      = DEF_TLP_LEN_W,
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rd_req_start_i,
    input  logic [LEN_W-1:0]     rd_req_len_i,
    input  logic                 rd_cpl_valid_i,
    input  logic [TLP_LEN_W-1:0] rd_cpl_len_i,
    input  logic                 wr_req_start_i,
    input  logic [LEN_W-1:0]     wr_req_len_i,
    input  logic                 wr_tlp_sent_i,
    input  logic [TLP_LEN_W-1:0] wr_tlp_len_i,
    output logic                 rd_req_done_o,
    output logic                 wr_req_done_o,
    output logic                 rd_busy_o,
    output logic                 wr_busy_o,
    output logic [1:0]           rd_status_o,
    output logic [1:0]           wr_status_o,
    output logic [31:0]          rd_done_cnt_o,
    output logic [31:0]          wr_done_cnt_o
);

    dma_chan_tracker #(
        .LEN_W          (LEN_W),
        .TLP_LEN_W      (TLP_LEN_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (rd_req_start_i),
        .req_len   (rd_req_len_i),
        .tlp_valid (rd_cpl_valid_i),
        .tlp_len   (rd_cpl_len_i),
        .done      (rd_req_done_o),
        .busy      (rd_busy_o),
        .status    (rd_status_o),
        .done_cnt  (rd_done_cnt_o)
    );

    dma_chan_tracker #(
        .LEN_W          (LEN_W),
        .TLP_LEN_W      (TLP_LEN_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wr (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (wr_req_start_i),
        .req_len   (wr_req_len_i),
        .tlp_valid (wr_tlp_sent_i),
        .tlp_len   (wr_tlp_len_i),
        .done      (wr_req_done_o),
        .busy      (wr_busy_o),
        .status    (wr_status_o),
        .done_cnt  (wr_done_cnt_o)
    );

endmodule

// File: tb/tb_dma_done_tracker.sv
// tb_dma_done_tracker
//   Directed bench for dma_done_tracker with a short timeout (16 cycles).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that
//   same point, i.e. they reflect the edge just taken.
module tb_dma_done_tracker;

    localparam int          LEN_W   = 16;
    localparam int          TLP_W   = 10;
    localparam logic [31:0] TMO     = 32'd16;

    logic              clk = 1'b0;
    logic              rst_n, en;
    logic              rd_req_start_i, rd_cpl_valid_i;
    logic [LEN_W-1:0]  rd_req_len_i;
    logic [TLP_W-1:0]  rd_cpl_len_i;
    logic              wr_req_start_i, wr_tlp_sent_i;
    logic [LEN_W-1:0]  wr_req_len_i;
    logic [TLP_W-1:0]  wr_tlp_len_i;
    logic              rd_req_done_o, wr_req_done_o, rd_busy_o, wr_busy_o;
    logic [1:0]        rd_status_o, wr_status_o;
    logic [31:0]       rd_done_cnt_o, wr_done_cnt_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dma_done_tracker #(
        .LEN_W          (LEN_W),
        .TLP_LEN_W      (TLP_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .rd_req_start_i (rd_req_start_i),
        .rd_req_len_i   (rd_req_len_i),
        .rd_cpl_valid_i (rd_cpl_valid_i),
        .rd_cpl_len_i   (rd_cpl_len_i),
        .wr_req_start_i (wr_req_start_i),
        .wr_req_len_i   (wr_req_len_i),
        .wr_tlp_sent_i  (wr_tlp_sent_i),
        .wr_tlp_len_i   (wr_tlp_len_i),
        .rd_req_done_o  (rd_req_done_o),
        .wr_req_done_o  (wr_req_done_o),
        .rd_busy_o      (rd_busy_o),
        .wr_busy_o      (wr_busy_o),
        .rd_status_o    (rd_status_o),
        .wr_status_o    (wr_status_o),
        .rd_done_cnt_o  (rd_done_cnt_o),
        .wr_done_cnt_o  (wr_done_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        rd_req_start_i = 1'b0;
        rd_cpl_valid_i = 1'b0;
        wr_req_start_i = 1'b0;
        wr_tlp_sent_i  = 1'b0;
    endtask

    task automatic rd_start(input logic [LEN_W-1:0] len);
        rd_req_start_i = 1'b1;
        rd_req_len_i   = len;
        tick();
        clear_pulses();
    endtask

    task automatic rd_cpl(input logic [TLP_W-1:0] len);
        rd_cpl_valid_i = 1'b1;
        rd_cpl_len_i   = len;
        tick();
        clear_pulses();
    endtask

    task automatic wr_tlp(input logic [TLP_W-1:0] len);
        wr_tlp_sent_i = 1'b1;
        wr_tlp_len_i  = len;
        tick();
        clear_pulses();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        clear_pulses();
        rd_req_len_i = '0; rd_cpl_len_i = '0;
        wr_req_len_i = '0; wr_tlp_len_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        nvec++;
        if ({rd_req_done_o, rd_busy_o, rd_status_o} !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_rd_flags: got %b want 0000", {rd_req_done_o, rd_busy_o, rd_status_o});
        end
        nvec++;
        if ({wr_req_done_o, wr_busy_o, wr_status_o} !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_wr_flags: got %b want 0000", {wr_req_done_o, wr_busy_o, wr_status_o});
        end
        nvec++;
        if ({rd_done_cnt_o, wr_done_cnt_o} !== 64'd0) begin
            nerr++;
            $display("FAIL reset_cnts: got rd %0d wr %0d want 0 0", rd_done_cnt_o, wr_done_cnt_o);
        end
    endtask

    task automatic test_read_basic();
        rd_start(16'd64);
        nvec++;
        if ({rd_busy_o, rd_req_done_o} !== 2'b10) begin
            nerr++;
            $display("FAIL rd_basic_enter_busy: got busy,done=%b want 10", {rd_busy_o, rd_req_done_o});
        end
        for (int i = 0; i < 3; i++) rd_cpl(10'd16);
        nvec++;
        if ({rd_busy_o, rd_req_done_o} !== 2'b10) begin
            nerr++;
            $display("FAIL rd_basic_after3: got busy,done=%b want 10", {rd_busy_o, rd_req_done_o});
        end
        rd_cpl(10'd16);
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0100 || rd_done_cnt_o !== 32'd1) begin
            nerr++;
            $display("FAIL rd_basic_done: got busy,done,st=%b cnt=%0d want 0100 cnt=1",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
        nvec++;
        if ({wr_req_done_o, wr_busy_o, wr_status_o} !== 4'b0000 || wr_done_cnt_o !== 32'd0) begin
            nerr++;
            $display("FAIL rd_basic_wr_untouched: got %b cnt=%0d want 0000 cnt=0",
                     {wr_req_done_o, wr_busy_o, wr_status_o}, wr_done_cnt_o);
        end
        rd_cpl(10'd16);
        nvec++;
        if (rd_req_done_o !== 1'b1 || rd_done_cnt_o !== 32'd1 || rd_status_o !== 2'b00) begin
            nerr++;
            $display("FAIL rd_cpl_in_done_ignored: got done=%b cnt=%0d st=%b want 1 1 00",
                     rd_req_done_o, rd_done_cnt_o, rd_status_o);
        end
    endtask

    task automatic test_write_overrun();
        wr_req_start_i = 1'b1;
        wr_req_len_i   = 16'd100;
        tick();
        clear_pulses();
        for (int i = 0; i < 3; i++) wr_tlp(10'd32);
        nvec++;
        if (dut.u_wr.remaining !== 16'd4 || {wr_busy_o, wr_req_done_o} !== 2'b10) begin
            nerr++;
            $display("FAIL wr_after3_remaining: got rem=%0d busy,done=%b want rem=4 10",
                     dut.u_wr.remaining, {wr_busy_o, wr_req_done_o});
        end
        wr_tlp(10'd8);
        nvec++;
        if ({wr_busy_o, wr_req_done_o, wr_status_o} !== 4'b0101 || wr_done_cnt_o !== 32'd1) begin
            nerr++;
            $display("FAIL wr_overrun: got busy,done,st=%b cnt=%0d want 0101 cnt=1",
                     {wr_busy_o, wr_req_done_o, wr_status_o}, wr_done_cnt_o);
        end
    endtask

    task automatic test_timeout();
        rd_start(16'd8);
        for (int i = 0; i < 15; i++) tick();
        nvec++;
        if ({rd_busy_o, rd_req_done_o} !== 2'b10) begin
            nerr++;
            $display("FAIL tmo_early: got busy,done=%b after 15 cycles want 10", {rd_busy_o, rd_req_done_o});
        end
        tick();
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0110 || rd_done_cnt_o !== 32'd2) begin
            nerr++;
            $display("FAIL tmo_fire: got busy,done,st=%b cnt=%0d want 0110 cnt=2",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
        rd_cpl(10'd8);
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0110 || rd_done_cnt_o !== 32'd2) begin
            nerr++;
            $display("FAIL tmo_late_cpl: got busy,done,st=%b cnt=%0d want 0110 cnt=2",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        rd_start(16'd32);
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b1000) begin
            nerr++;
            $display("FAIL b2b_first_accept: got busy,done,st=%b want 1000 (done drops, status clears)",
                     {rd_busy_o, rd_req_done_o, rd_status_o});
        end
        rd_req_start_i = 1'b1;
        rd_req_len_i   = 16'd32;
        rd_cpl_valid_i = 1'b1;
        rd_cpl_len_i   = 10'd32;
        tick();
        clear_pulses();
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0111 || rd_done_cnt_o !== 32'd3) begin
            nerr++;
            $display("FAIL b2b_start_dropped: got busy,done,st=%b cnt=%0d want 0111 cnt=3",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
        tick();
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0111 || rd_done_cnt_o !== 32'd3) begin
            nerr++;
            $display("FAIL b2b_stays_done: got busy,done,st=%b cnt=%0d want 0111 cnt=3",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
    endtask

    task automatic test_len_1024_and_zero();
        rd_start(16'd1024);
        rd_cpl(10'd0);
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0100 || rd_done_cnt_o !== 32'd4) begin
            nerr++;
            $display("FAIL len1024_cpl0: got busy,done,st=%b cnt=%0d want 0100 cnt=4",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
        rd_start(16'd0);
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0100 || rd_done_cnt_o !== 32'd5) begin
            nerr++;
            $display("FAIL start_len0: got busy,done,st=%b cnt=%0d want 0100 cnt=5",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
    endtask

    task automatic test_en_abort();
        rd_start(16'd64);
        rd_cpl(10'd16);
        nvec++;
        if ({rd_busy_o, rd_req_done_o} !== 2'b10) begin
            nerr++;
            $display("FAIL abort_pre_busy: got busy,done=%b want 10", {rd_busy_o, rd_req_done_o});
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0000 || rd_done_cnt_o !== 32'd0) begin
            nerr++;
            $display("FAIL abort_rd_cleared: got busy,done,st=%b cnt=%0d want 0000 cnt=0",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
        nvec++;
        if ({wr_busy_o, wr_req_done_o, wr_status_o} !== 4'b0000 || wr_done_cnt_o !== 32'd0) begin
            nerr++;
            $display("FAIL abort_wr_cleared: got busy,done,st=%b cnt=%0d want 0000 cnt=0",
                     {wr_busy_o, wr_req_done_o, wr_status_o}, wr_done_cnt_o);
        end
        for (int i = 0; i < 4; i++) rd_cpl(10'd16);
        nvec++;
        if ({rd_busy_o, rd_req_done_o, rd_status_o} !== 4'b0000 || rd_done_cnt_o !== 32'd0) begin
            nerr++;
            $display("FAIL abort_late_cpls: got busy,done,st=%b cnt=%0d want 0000 cnt=0",
                     {rd_busy_o, rd_req_done_o, rd_status_o}, rd_done_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_overrun();
        test_timeout();
        test_back_to_back();
        test_len_1024_and_zero();
        test_en_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
